// File: rtl/rom_readback_if.sv
`default_nettype none
// ============================================================================
// rom_readback_if : Avalon-MM register port plus byte-wide PRG/CHR ROM port
// Rev 1.0 - initial release
// ============================================================================
interface rom_readback_if;
    logic [1:0]  AVL_ADDR;
    logic        AVL_CS;
    logic        AVL_READ;
    logic        AVL_WRITE;
    logic [31:0] AVL_WRITEDATA;
    logic [31:0] AVL_READDATA;
    logic [15:0] ROM_ADDR;
    logic        PRG_ROM_RD;
    logic        CHR_ROM_RD;
    logic [7:0]  PRG_ROM_Q;
    logic [7:0]  CHR_ROM_Q;

    // Host side: owns the Avalon request and models the ROM data return.
    modport master (
        output AVL_ADDR, AVL_CS, AVL_READ, AVL_WRITE, AVL_WRITEDATA,
        output PRG_ROM_Q, CHR_ROM_Q,
        input  AVL_READDATA, ROM_ADDR, PRG_ROM_RD, CHR_ROM_RD
    );

    modport slave (
        input  AVL_ADDR, AVL_CS, AVL_READ, AVL_WRITE, AVL_WRITEDATA,
        input  PRG_ROM_Q, CHR_ROM_Q,
        output AVL_READDATA, ROM_ADDR, PRG_ROM_RD, CHR_ROM_RD
    );
endinterface
`default_nettype wire

// File: rtl/rom_readback.sv
`default_nettype none
// ============================================================================
// rom_readback : scans a PRG or CHR ROM range and accumulates a byte checksum
// Rev 1.0 - initial release
// ============================================================================
module rom_readback #(
    parameter int READ_LATENCY = 1      // legal 1..3
) (
    input  wire logic     CLK,
    input  wire logic     RESET_N,
    rom_readback_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_LENGTH   = 2'd1;
    localparam logic [1:0] REG_STATUS   = 2'd2;
    localparam logic [1:0] REG_CHECKSUM = 2'd3;

    localparam logic [READ_LATENCY-1:0] VP_OLDEST = READ_LATENCY'(1) << (READ_LATENCY - 1);

    state_t                  state;
    logic                    sel;
    logic [15:0]             start_addr;
    logic [16:0]             length;
    logic [16:0]             remaining;
    logic                    done;
    logic                    ovr;
    logic [31:0]             checksum;
    logic [7:0]              last_byte;
    logic [15:0]             next_addr;
    logic [15:0]             rom_addr;
    logic                    prg_rd;
    logic                    chr_rd;
    logic [READ_LATENCY-1:0] valid_pipe;
    logic [31:0]             readdata;

    logic       wr_en;
    logic       rd_en;
    logic       busy;
    logic       ctrl_wr;
    logic       start_req;
    logic       len_wr;
    logic       data_valid;
    logic       pipe_last;
    logic [7:0] rom_q;
    logic       unused_wdata_bits;

    assign wr_en      = bus.AVL_CS & bus.AVL_WRITE;
    assign rd_en      = bus.AVL_CS & bus.AVL_READ;
    assign busy       = (state != IDLE);
    assign ctrl_wr    = wr_en && (bus.AVL_ADDR == REG_CTRL);
    assign start_req  = ctrl_wr && bus.AVL_WRITEDATA[29];
    assign len_wr     = wr_en && (bus.AVL_ADDR == REG_LENGTH);
    assign data_valid = valid_pipe[READ_LATENCY-1];
    // True when the datum at the pipe output is the only read still in flight.
    assign pipe_last  = ((valid_pipe & ~VP_OLDEST) == '0);
    assign rom_q      = sel ? bus.PRG_ROM_Q : bus.CHR_ROM_Q;

    assign unused_wdata_bits = ^{bus.AVL_WRITEDATA[30], bus.AVL_WRITEDATA[28:17]};

    assign bus.AVL_READDATA = readdata;
    assign bus.ROM_ADDR     = rom_addr;
    assign bus.PRG_ROM_RD   = prg_rd;
    assign bus.CHR_ROM_RD   = chr_rd;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            sel        <= 1'b0;
            start_addr <= 16'd0;
            length     <= 17'd0;
            remaining  <= 17'd0;
            done       <= 1'b0;
            ovr        <= 1'b0;
            checksum   <= 32'd0;
            last_byte  <= 8'd0;
            next_addr  <= 16'd0;
            rom_addr   <= 16'd0;
            prg_rd     <= 1'b0;
            chr_rd     <= 1'b0;
            valid_pipe <= '0;
        end else begin
            valid_pipe <= (valid_pipe << 1) | READ_LATENCY'(prg_rd | chr_rd);

            if (data_valid) begin
                checksum  <= checksum + {24'd0, rom_q};
                last_byte <= rom_q;
            end

            case (state)
                IDLE: begin
                    if (len_wr) begin
                        length <= bus.AVL_WRITEDATA[16:0];
                    end
                    if (ctrl_wr) begin
                        sel        <= bus.AVL_WRITEDATA[31];
                        start_addr <= bus.AVL_WRITEDATA[15:0];
                    end
                    if (start_req) begin
                        checksum  <= 32'd0;
                        ovr       <= 1'b0;
                        next_addr <= bus.AVL_WRITEDATA[15:0];
                        if (length == 17'd0) begin
                            done <= 1'b1;
                        end else begin
                            done      <= 1'b0;
                            state     <= ISSUE;
                            remaining <= length;
                            rom_addr  <= bus.AVL_WRITEDATA[15:0];
                            prg_rd    <= bus.AVL_WRITEDATA[31];
                            chr_rd    <= ~bus.AVL_WRITEDATA[31];
                        end
                    end
                end

                ISSUE: begin
                    if (start_req || len_wr) begin
                        ovr <= 1'b1;
                    end
                    next_addr <= next_addr + 16'd1;
                    remaining <= remaining - 17'd1;
                    if (remaining == 17'd1) begin
                        prg_rd <= 1'b0;
                        chr_rd <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        rom_addr <= rom_addr + 16'd1;
                    end
                end

                DRAIN: begin
                    if (start_req || len_wr) begin
                        ovr <= 1'b1;
                    end
                    if (data_valid && pipe_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end

                default: begin
                    prg_rd <= 1'b0;
                    chr_rd <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            readdata <= 32'd0;
        end else if (rd_en) begin
            case (bus.AVL_ADDR)
                REG_CTRL:     readdata <= {sel, 15'd0, start_addr};
                REG_LENGTH:   readdata <= {15'd0, length};
                REG_STATUS:   readdata <= {busy, done, ovr, 5'd0, last_byte, next_addr};
                REG_CHECKSUM: readdata <= checksum;
                default:      readdata <= 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_readback.sv
`default_nettype none
// Bench for rom_readback: directed table, corner-case sequences and random
// scans against a ROM model and a whole-scan reference computed from memory.
module tb_rom_readback;
    localparam int RL = 3;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b0;

    rom_readback_if bus ();

    rom_readback #(.READ_LATENCY(RL)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus.slave)
    );

    always #5 CLK = ~CLK;

    int ecnt = 0;
    always @(posedge CLK) ecnt <= ecnt + 1;

    // ROM model: data appears RL cycles after the strobe, junk otherwise.
    logic [7:0]           prg_mem [0:65535];
    logic [7:0]           chr_mem [0:65535];
    logic [RL-1:0]        prg_v = '0;
    logic [RL-1:0]        chr_v = '0;
    logic [RL-1:0][15:0]  rom_a = '0;
    logic [7:0]           junk  = 8'h5A;

    always @(posedge CLK) begin
        prg_v <= (prg_v << 1) | RL'(bus.PRG_ROM_RD);
        chr_v <= (chr_v << 1) | RL'(bus.CHR_ROM_RD);
        rom_a <= {rom_a[RL-2:0], bus.ROM_ADDR};
        junk  <= 8'($urandom);
    end

    assign bus.PRG_ROM_Q = prg_v[RL-1] ? prg_mem[rom_a[RL-1]] : junk;
    assign bus.CHR_ROM_Q = chr_v[RL-1] ? chr_mem[rom_a[RL-1]] : junk;

    typedef struct {
        int          off;
        logic        prg;
        logic        chr;
        logic [15:0] addr;
    } strobe_t;

    strobe_t strobes[$];
    int      scan_edge = 0;
    int      wr_edge   = 0;

    always @(negedge CLK) begin
        if (bus.PRG_ROM_RD || bus.CHR_ROM_RD)
            strobes.push_back('{ecnt - scan_edge + 1, bus.PRG_ROM_RD, bus.CHR_ROM_RD, bus.ROM_ADDR});
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic avl_write(input logic [1:0] addr, input logic [31:0] data);
        bus.AVL_ADDR      = addr;
        bus.AVL_WRITEDATA = data;
        bus.AVL_CS        = 1'b1;
        bus.AVL_WRITE     = 1'b1;
        @(posedge CLK); #1;
        wr_edge       = ecnt;
        bus.AVL_CS    = 1'b0;
        bus.AVL_WRITE = 1'b0;
    endtask

    task automatic avl_read(input logic [1:0] addr, output logic [31:0] data);
        bus.AVL_ADDR = addr;
        bus.AVL_CS   = 1'b1;
        bus.AVL_READ = 1'b1;
        @(posedge CLK); #1;
        data         = bus.AVL_READDATA;
        bus.AVL_CS   = 1'b0;
        bus.AVL_READ = 1'b0;
    endtask

    task automatic start_scan(input logic s, input logic [15:0] a, input int n, input bit wr_len);
        if (wr_len) avl_write(2'd1, 32'(n));
        strobes.delete();
        avl_write(2'd0, {s, 2'b01, 13'd0, a});
        scan_edge = wr_edge;
    endtask

    function automatic logic [31:0] model_sum(input logic s, input logic [15:0] a, input int n);
        logic [31:0] sum = 32'd0;
        for (int i = 0; i < n; i++)
            sum += {24'd0, (s ? prg_mem[16'(a + i)] : chr_mem[16'(a + i)])};
        return sum;
    endfunction

    task automatic finish_scan(input string tag, input logic s, input logic [15:0] a, input int n,
                               input logic [31:0] e_sum, input logic [7:0] e_last,
                               input logic [15:0] e_next, input logic e_ovr);
        logic [31:0] rdv;
        int          done_off = -1;
        logic        first_busy = 1'b0;
        int          bad = 0;
        bus.AVL_ADDR = 2'd2;
        bus.AVL_CS   = 1'b1;
        bus.AVL_READ = 1'b1;
        for (int k = 0; k < 70000; k++) begin
            @(posedge CLK); #1;
            if (k == 0) first_busy = bus.AVL_READDATA[31];
            if (bus.AVL_READDATA[30]) begin
                done_off = ecnt - scan_edge;
                break;
            end
        end
        bus.AVL_CS   = 1'b0;
        bus.AVL_READ = 1'b0;
        check($sformatf("%s busy_early", tag), {31'd0, first_busy}, {31'd0, n != 0});
        check($sformatf("%s done_cycle", tag), done_off, (n == 0) ? 1 : n + RL + 1);
        avl_read(2'd2, rdv);
        check($sformatf("%s status_flags", tag), {24'd0, rdv[31:24]}, {24'd0, 2'b01, e_ovr, 5'd0});
        check($sformatf("%s last_byte", tag), {24'd0, rdv[23:16]}, {24'd0, e_last});
        check($sformatf("%s next_addr", tag), {16'd0, rdv[15:0]}, {16'd0, e_next});
        avl_read(2'd3, rdv);
        check($sformatf("%s checksum", tag), rdv, e_sum);
        check($sformatf("%s strobe_count", tag), strobes.size(), n);
        foreach (strobes[i])
            if (strobes[i].off != i + 1 || strobes[i].addr != 16'(a + i) ||
                strobes[i].prg != s || strobes[i].chr != !s) bad++;
        check($sformatf("%s strobe_seq_bad", tag), bad, 0);
    endtask

    typedef struct {
        logic        s;
        logic [15:0] a;
        int          n;
        logic [31:0] sum;
        logic [7:0]  last;
        logic [15:0] next;
    } vec_t;

    vec_t        tbl [5];
    logic [31:0] rdv;

    initial begin
        bus.AVL_ADDR      = 2'd0;
        bus.AVL_CS        = 1'b0;
        bus.AVL_READ      = 1'b0;
        bus.AVL_WRITE     = 1'b0;
        bus.AVL_WRITEDATA = 32'd0;

        for (int i = 0; i < 65536; i++) begin
            prg_mem[i] = 8'($urandom);
            chr_mem[i] = 8'($urandom);
        end
        prg_mem[16'h8000] = 8'h01; prg_mem[16'h8001] = 8'h02;
        prg_mem[16'h8002] = 8'h03; prg_mem[16'h8003] = 8'h04;
        chr_mem[16'hFFFE] = 8'h10; chr_mem[16'hFFFF] = 8'h20;
        chr_mem[16'h0000] = 8'h30; chr_mem[16'h0001] = 8'h40;

        tbl[0] = '{1'b1, 16'h8000, 4, 32'h0000000A, 8'h04, 16'h8004};
        tbl[1] = '{1'b0, 16'hFFFE, 4, 32'h000000A0, 8'h40, 16'h0002};
        tbl[2] = '{1'b1, 16'h1234, 0, 32'h00000000, 8'h40, 16'h1234};
        tbl[3] = '{1'b1, 16'h8003, 1, 32'h00000004, 8'h04, 16'h8004};
        tbl[4] = '{1'b0, 16'h0000, 2, 32'h00000070, 8'h40, 16'h0002};

        // Reset state
        @(posedge CLK); #1;
        check("rst readdata", bus.AVL_READDATA, 32'd0);
        check("rst rom_addr", {16'd0, bus.ROM_ADDR}, 32'd0);
        check("rst strobes", {30'd0, bus.PRG_ROM_RD, bus.CHR_ROM_RD}, 32'd0);
        @(negedge CLK); RESET_N = 1'b1;
        @(posedge CLK); #1;
        avl_read(2'd2, rdv); check("rst status", rdv, 32'd0);
        avl_read(2'd3, rdv); check("rst checksum", rdv, 32'd0);

        for (int v = 0; v < 5; v++) begin
            start_scan(tbl[v].s, tbl[v].a, tbl[v].n, 1'b1);
            finish_scan($sformatf("tbl%0d", v), tbl[v].s, tbl[v].a, tbl[v].n,
                        tbl[v].sum, tbl[v].last, tbl[v].next, 1'b0);
        end

        // Start while busy: ignored, OVR set
        start_scan(1'b1, 16'h8000, 4, 1'b1);
        @(posedge CLK); #1;
        avl_write(2'd0, {1'b0, 2'b01, 13'd0, 16'h0100});
        finish_scan("ovr_start", 1'b1, 16'h8000, 4, 32'h0A, 8'h04, 16'h8004, 1'b1);

        // CTRL without start while busy: ignored, no OVR
        start_scan(1'b0, 16'hFFFE, 4, 1'b1);
        @(posedge CLK); #1;
        avl_write(2'd0, 32'h0000_0100);
        finish_scan("ctrl_nostart", 1'b0, 16'hFFFE, 4, 32'hA0, 8'h40, 16'h0002, 1'b0);

        // LENGTH while busy: ignored (old length kept), OVR set
        start_scan(1'b1, 16'h8000, 4, 1'b1);
        @(posedge CLK); #1;
        avl_write(2'd1, 32'd9);
        finish_scan("ovr_len", 1'b1, 16'h8000, 4, 32'h0A, 8'h04, 16'h8004, 1'b1);
        start_scan(1'b1, 16'h8000, 4, 1'b0);
        finish_scan("len_kept", 1'b1, 16'h8000, 4, 32'h0A, 8'h04, 16'h8004, 1'b0);

        // Simultaneous read and write: write must take effect
        bus.AVL_ADDR = 2'd1; bus.AVL_WRITEDATA = 32'd2;
        bus.AVL_CS = 1'b1; bus.AVL_READ = 1'b1; bus.AVL_WRITE = 1'b1;
        @(posedge CLK); #1;
        bus.AVL_CS = 1'b0; bus.AVL_READ = 1'b0; bus.AVL_WRITE = 1'b0;
        start_scan(1'b1, 16'h8001, 2, 1'b0);
        finish_scan("rw_same", 1'b1, 16'h8001, 2, 32'h05, 8'h03, 16'h8003, 1'b0);

        // Reset in the middle of a scan
        start_scan(1'b1, 16'h8000, 8, 1'b1);
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        #1;
        check("midrst prg_rd", {31'd0, bus.PRG_ROM_RD}, 32'd0);
        check("midrst rom_addr", {16'd0, bus.ROM_ADDR}, 32'd0);
        check("midrst readdata", bus.AVL_READDATA, 32'd0);
        @(negedge CLK); RESET_N = 1'b1;
        repeat (RL + 4) @(posedge CLK);
        #1;
        avl_read(2'd3, rdv); check("midrst checksum", rdv, 32'd0);
        avl_read(2'd2, rdv); check("midrst status", rdv, 32'd0);
        repeat (5) @(posedge CLK);
        #1;
        avl_read(2'd3, rdv); check("midrst checksum_hold", rdv, 32'd0);

        // Randomized scans against the reference model
        for (int r = 0; r < 16; r++) begin
            logic        s;
            logic [15:0] a;
            int          n;
            s = 1'($urandom);
            a = (r % 4 == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
            n = $urandom_range(1, 48);
            start_scan(s, a, n, 1'b1);
            finish_scan($sformatf("rnd%0d", r), s, a, n, model_sum(s, a, n),
                        s ? prg_mem[16'(a + n - 1)] : chr_mem[16'(a + n - 1)],
                        16'(a + n), 1'b0);
        end

        // Full 64 KiB scan of 0xFF bytes
        for (int i = 0; i < 65536; i++) prg_mem[i] = 8'hFF;
        start_scan(1'b1, 16'h1234, 65536, 1'b1);
        finish_scan("full64k", 1'b1, 16'h1234, 65536, 32'h00FF0000, 8'hFF, 16'h1234, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rom_readback.md
ROM_READBACK -- requirements
Module: rom_readback

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1, the ROM read latency in cycles (legal 1..3).
REQ-002 SHALL have port CLK  in  1  system clock; all state on rising edge.
REQ-003 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port AVL_ADDR  in  2  Avalon MM register select.
REQ-005 SHALL have port AVL_CS  in  1  Avalon chip select.
REQ-006 SHALL have port AVL_READ  in  1  Avalon read strobe.
REQ-007 SHALL have port AVL_WRITE  in  1  Avalon write strobe.
REQ-008 SHALL have port AVL_WRITEDATA  in  32  Avalon write data.
REQ-009 SHALL have port AVL_READDATA  out  32  Avalon read data, registered.
REQ-010 SHALL have port ROM_ADDR  out  16  ROM read address.
REQ-011 SHALL have port PRG_ROM_RD  out  1  PRG ROM read strobe.
REQ-012 SHALL have port CHR_ROM_RD  out  1  CHR ROM read strobe.
REQ-013 SHALL have port PRG_ROM_Q  in  8  PRG ROM data, valid READ_LATENCY cycles after strobe.
REQ-014 SHALL have port CHR_ROM_Q  in  8  CHR ROM data, valid READ_LATENCY cycles after strobe.

Function
REQ-015 Register map SHALL be: 0 CTRL (W), 1 LENGTH (W), 2 STATUS (R), 3 CHECKSUM (R).
REQ-016 CTRL write SHALL latch SEL=[31] (1 PRG, 0 CHR) and START_ADDR=[15:0]; when [29]=1 it SHALL also start a scan.
REQ-017 LENGTH write SHALL latch byte count [16:0] (0..65536); bits above ignored.
REQ-018 STATUS SHALL read {BUSY[31], DONE[30], OVR[29], 5'b0, LAST_BYTE[23:16], NEXT_ADDR[15:0]}.
REQ-019 CHECKSUM SHALL read the 32-bit sum, mod 2^32, of all bytes returned in the current/last scan.
REQ-020 AVL_READDATA SHALL be valid the cycle after AVL_CS&AVL_READ (read latency 1); unaddressed cycles SHALL hold prior value.
REQ-021 FSM SHALL have states IDLE, ISSUE, DRAIN; IDLE->ISSUE on accepted start with LENGTH>0; ISSUE->DRAIN after LENGTH reads issued; DRAIN->IDLE when last datum accumulated.
REQ-022 Accepted start (cycle T) SHALL clear CHECKSUM, DONE, OVR and set BUSY visible at T+1.
REQ-023 In ISSUE, one read per cycle SHALL issue on cycles T+1..T+N: ROM_ADDR=START_ADDR+i, strobe of selected ROM only high.
REQ-024 ROM_ADDR SHALL wrap 0xFFFF->0x0000 without error.
REQ-025 A valid-tracking shift register of depth READ_LATENCY SHALL mark returning data; each marked datum SHALL be added to CHECKSUM and stored in LAST_BYTE at that edge.
REQ-026 Last datum SHALL be accumulated at end of cycle T+N+READ_LATENCY; BUSY=0, DONE=1 SHALL be visible at T+N+READ_LATENCY+1.
REQ-027 LENGTH=0 start SHALL issue no reads, leave CHECKSUM=0, and show BUSY=0, DONE=1 at T+1.
REQ-028 Start or LENGTH write while BUSY SHALL be ignored and SHALL set OVR sticky until next accepted start.
REQ-029 CTRL write with [29]=0 while BUSY SHALL be ignored (no OVR); while idle it SHALL only update SEL/START_ADDR.
REQ-030 NEXT_ADDR SHALL equal the next address to issue, i.e. START_ADDR+N (mod 2^16) after completion.
REQ-031 Strobes SHALL be low in IDLE and DRAIN; ROM_ADDR SHALL hold its last value.
REQ-032 Simultaneous AVL_READ and AVL_WRITE SHALL service the write and return read data for AVL_ADDR.

Reset
REQ-033 RESET_N low SHALL immediately force IDLE, strobes 0, ROM_ADDR 0, BUSY/DONE/OVR 0, CHECKSUM 0, LAST_BYTE 0, SEL 0, START_ADDR 0, LENGTH 0, AVL_READDATA 0, valid pipe cleared.
REQ-034 Reset mid-scan SHALL abandon in-flight reads; data returning after release SHALL not be accumulated.

Verification
REQ-035 PRG 0x8000..0x8003 = 01,02,03,04; LENGTH=4, CTRL=0xA0008000 at T -> PRG_ROM_RD high T+1..T+4, CHECKSUM=0x0000000A, LAST_BYTE=0x04, NEXT_ADDR=0x8004, DONE at T+6.
REQ-036 CHR scan START_ADDR=0xFFFE, LENGTH=4 -> ROM_ADDR FFFE,FFFF,0000,0001; CHR_ROM_RD only; NEXT_ADDR=0x0002.
REQ-037 LENGTH=0 start -> no strobes, CHECKSUM=0, DONE=1 at T+1.
REQ-038 Second start at T+2 of 4-byte scan -> ignored, OVR=1, CHECKSUM equals first scan's sum.
REQ-039 LENGTH=65536, all bytes 0xFF, READ_LATENCY=3 -> CHECKSUM=0x00FF0000, DONE at T+65540.
REQ-040 RESET_N low at T+2 of a scan -> strobes and BUSY 0 same cycle; after release CHECKSUM=0 and stays 0.
